pc_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage. It holds the current fetch address and selects the next PC from:
- sequential increment
- taken conditional branch (PC-relative, shifted immediate)
- absolute jump
- call/return through an internal circular return-address stack (RAS)

It also supports fetch stall and issues a one-cycle redirect pulse for pipeline flush.

---
 rtl/pc_unit.sv | 150 +++++++++++++++
 tb/tb_pc_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the fetch stage.
// Each rising edge picks the next fetch address from one of these sources:
//   - sequential increment
//   - taken PC-relative branch
//   - absolute jump
//   - call or return through a circular return-address stack (RAS)
// redirect is registered with address and marks a non-sequential target.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   stall         hold PC, RAS and sticky flags
//   brnch_en      conditional branch; taken when zero_en is also high
//   zero_en       branch condition
//   imm_gen       signed offset, shifted by IMM_SHIFT, added to the PC
//   jump_en       absolute jump to jump_target
//   jump_target   absolute destination
//   call_en       push the return address, jump PC-relative
//   ret_en        pop a return address and jump to it
//   address       current PC (registered)
//   redirect      address holds a non-sequential target this cycle
//   ras_top       top RAS entry, 0 when the RAS is empty
//   ras_empty     RAS holds no entries
//   ras_full      RAS holds RAS_DEPTH entries
//   ras_ovf       sticky: a push happened while the RAS was full
//   ras_unf       sticky: a pop happened while the RAS was empty
module pc_unit #(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VEC = 40,
  parameter int unsigned      INCR      = 4,
  parameter int unsigned      IMM_SHIFT = 1,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             brnch_en,
  input  logic             zero_en,
  input  logic [WIDTH-1:0] imm_gen,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call_en,
  input  logic             ret_en,
  output logic [WIDTH-1:0] address,
  output logic             redirect,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] address_q, address_d;
  logic             redirect_q, redirect_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] seq, rel;
  logic [PW-1:0]    top_idx;
  logic             empty, full, push, pop;

  assign seq     = address_q + WIDTH'(INCR);
  assign rel     = address_q + (imm_gen << IMM_SHIFT);
  // The pointer addresses the next free slot, so the newest entry sits just below it.
  assign top_idx = ptr_q - PW'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));

  always_comb begin
    address_d  = seq;
    redirect_d = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (stall) begin
      address_d = address_q;
    end else if (ret_en) begin
      if (!empty) begin
        address_d  = ras_q[top_idx];
        pop        = 1'b1;
        redirect_d = 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end else if (call_en) begin
      push       = 1'b1;
      address_d  = rel;
      redirect_d = 1'b1;
      if (full) ovf_d = 1'b1;
    end else if (jump_en) begin
      address_d  = jump_target;
      redirect_d = 1'b1;
    end else if (brnch_en && zero_en) begin
      address_d  = rel;
      redirect_d = 1'b1;
    end
  end

  // When the RAS is full, the pointer already addresses the oldest entry, so a push
  // overwrites it and the count stays at RAS_DEPTH.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      address_q  <= RESET_VEC;
      redirect_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      address_q  <= address_d;
      redirect_q <= redirect_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Entry storage needs no reset; a zero count hides whatever it holds.
  always_ff @(posedge clk) begin
    if (!rst && push) ras_q[ptr_q] <= seq;
  end

  assign address   = address_q;
  assign redirect  = redirect_q;
  assign ras_top   = empty ? '0 : ras_q[top_idx];
  assign ras_empty = empty;
  assign ras_full  = full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit using default parameters.
// A queue-based reference model is checked against the DUT on every falling edge.
// Hand-computed literals pin the model along the directed sequence.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, brnch_en, zero_en, jump_en, call_en, ret_en;
  logic [63:0] imm_gen, jump_target;
  logic [63:0] address, ras_top;
  logic        redirect, ras_empty, ras_full, ras_ovf, ras_unf;

  pc_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .brnch_en   (brnch_en),
    .zero_en    (zero_en),
    .imm_gen    (imm_gen),
    .jump_en    (jump_en),
    .jump_target(jump_target),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .address    (address),
    .redirect   (redirect),
    .ras_top    (ras_top),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: the stack is a queue whose back holds the newest entry.
  logic [63:0] m_addr;
  logic        m_red, m_ovf, m_unf;
  logic [63:0] m_ras[$];

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_top();
    return (m_ras.size() == 0) ? 64'd0 : m_ras[m_ras.size()-1];
  endfunction

  task automatic model_update();
    if (rst) begin
      m_addr = 64'd40; m_red = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_ras.delete();
    end else if (stall) begin
      m_red = 1'b0;
    end else if (ret_en) begin
      if (m_ras.size() != 0) begin
        m_addr = m_ras.pop_back(); m_red = 1'b1;
      end else begin
        m_addr = m_addr + 64'd4; m_unf = 1'b1; m_red = 1'b0;
      end
    end else if (call_en) begin
      if (m_ras.size() == 4) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_ras.push_back(m_addr + 64'd4);
      m_addr = m_addr + (imm_gen << 1);
      m_red  = 1'b1;
    end else if (jump_en) begin
      m_addr = jump_target; m_red = 1'b1;
    end else if (brnch_en && zero_en) begin
      m_addr = m_addr + (imm_gen << 1); m_red = 1'b1;
    end else begin
      m_addr = m_addr + 64'd4; m_red = 1'b0;
    end
  endtask

  // Single compare process, run on every cycle once the model is initialised.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("address",   address,          m_addr);
      cmp("redirect",  64'(redirect),    64'(m_red));
      cmp("ras_top",   ras_top,          m_top());
      cmp("ras_empty", 64'(ras_empty),   64'(m_ras.size() == 0));
      cmp("ras_full",  64'(ras_full),    64'(m_ras.size() == 4));
      cmp("ras_ovf",   64'(ras_ovf),     64'(m_ovf));
      cmp("ras_unf",   64'(ras_unf),     64'(m_unf));
    end
  end

  // Drive one cycle of inputs, then leave the sampling point at the next falling edge.
  // Argument order: rst stall brnch zero jump call ret imm target.
  task automatic step(input logic r, s, b, z, j, c, t,
                      input logic [63:0] imm, input logic [63:0] tgt);
    rst = r; stall = s; brnch_en = b; zero_en = z; jump_en = j;
    call_en = c; ret_en = t; imm_gen = imm; jump_target = tgt;
    @(posedge clk);
    model_update();
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
  endtask

  task automatic do_rst();
    step(1, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
  endtask

  localparam logic [63:0] TopAddr = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    rst = 1'b1; stall = 1'b0; brnch_en = 1'b0; zero_en = 1'b0; jump_en = 1'b0;
    call_en = 1'b0; ret_en = 1'b0; imm_gen = '0; jump_target = '0;
    @(negedge clk);

    // Reset values followed by sequential fetch.
    do_rst();
    cmp("lit_rst_addr", address, 64'd40);
    cmp("lit_rst_red", 64'(redirect), 64'd0);
    cmp("lit_rst_empty", 64'(ras_empty), 64'd1);
    cmp("lit_rst_top", ras_top, 64'd0);
    idle(); idle();
    cmp("lit_seq_48", address, 64'd48);
    idle();
    cmp("lit_seq_52", address, 64'd52);

    // A branch whose condition is false falls through to the next address.
    do_rst(); idle(); idle();
    step(0, 0, 1, 0, 0, 0, 0, 64'd8, 64'd0);
    cmp("lit_br_nt", address, 64'd52);
    cmp("lit_br_nt_red", 64'(redirect), 64'd0);

    // Taken branches, forward then backward, on consecutive cycles.
    do_rst(); idle(); idle();
    step(0, 0, 1, 1, 0, 0, 0, 64'd8, 64'd0);
    cmp("lit_br_t", address, 64'd64);
    cmp("lit_br_t_red", 64'(redirect), 64'd1);
    step(0, 0, 1, 1, 0, 0, 0, -64'd2, 64'd0);
    cmp("lit_br_neg", address, 64'd60);
    idle();
    cmp("lit_br_red_drop", 64'(redirect), 64'd0);

    // Call followed by return.
    do_rst();
    step(0, 0, 0, 0, 0, 1, 0, 64'd50, 64'd0);
    cmp("lit_call_addr", address, 64'd140);
    cmp("lit_call_top", ras_top, 64'd44);
    idle();
    cmp("lit_call_seq", address, 64'd144);
    step(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0);
    cmp("lit_ret_addr", address, 64'd44);
    cmp("lit_ret_empty", 64'(ras_empty), 64'd1);
    cmp("lit_ret_red", 64'(redirect), 64'd1);

    // Five calls from 40, 44, 48, 52 and 56 push 44..60. The fifth call overwrites 44.
    do_rst();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0, 64'd2, 64'd0);
    cmp("lit_ovf_full", 64'(ras_full), 64'd1);
    cmp("lit_ovf_flag", 64'(ras_ovf), 64'd1);
    cmp("lit_ovf_top", ras_top, 64'd60);
    step(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0);
    cmp("lit_ret1", address, 64'd60);
    step(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0);
    cmp("lit_ret2", address, 64'd56);
    step(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0);
    cmp("lit_ret3", address, 64'd52);
    step(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0);
    cmp("lit_ret4", address, 64'd48);
    step(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0);
    cmp("lit_unf_addr", address, 64'd52);
    cmp("lit_unf_flag", 64'(ras_unf), 64'd1);
    cmp("lit_unf_red", 64'(redirect), 64'd0);

    // A stall holds the PC. The jump held through the stall is taken on the next cycle.
    step(0, 1, 0, 0, 1, 0, 0, 64'd0, 64'd500);
    cmp("lit_stall_hold", address, 64'd52);
    cmp("lit_stall_red", 64'(redirect), 64'd0);
    step(0, 0, 0, 0, 1, 0, 0, 64'd0, 64'd500);
    cmp("lit_stall_release", address, 64'd500);

    // With ret, jump and call all requested, the return wins and nothing is pushed.
    step(0, 0, 0, 0, 0, 1, 0, 64'd2, 64'd0);
    cmp("lit_pri_call", ras_top, 64'd504);
    step(0, 0, 0, 0, 1, 1, 1, 64'd2, 64'd900);
    cmp("lit_pri_ret", address, 64'd504);
    cmp("lit_pri_nopush", 64'(ras_empty), 64'd1);

    // A jump beats a taken branch.
    step(0, 0, 1, 1, 1, 0, 0, 64'd8, 64'd1000);
    cmp("lit_pri_jump", address, 64'd1000);

    // Reset during a stall clears everything, including a non-empty RAS.
    step(0, 0, 0, 0, 0, 1, 0, 64'd4, 64'd0);
    cmp("lit_pre_rst_top", ras_top, 64'd1004);
    step(1, 1, 0, 0, 0, 0, 0, 64'd0, 64'd0);
    cmp("lit_rst_stall_addr", address, 64'd40);
    cmp("lit_rst_stall_empty", 64'(ras_empty), 64'd1);
    cmp("lit_rst_stall_ovf", 64'(ras_ovf), 64'd0);
    cmp("lit_rst_stall_unf", 64'(ras_unf), 64'd0);

    // Address arithmetic wraps around at 2^64.
    step(0, 0, 0, 0, 1, 0, 0, 64'd0, TopAddr);
    cmp("lit_wrap_jump", address, TopAddr);
    idle();
    cmp("lit_wrap_seq", address, 64'd0);
    step(0, 0, 0, 0, 1, 0, 0, 64'd0, TopAddr);
    step(0, 0, 0, 0, 0, 1, 0, 64'd0, 64'd0);
    cmp("lit_wrap_call_addr", address, TopAddr);
    cmp("lit_wrap_push0", ras_top, 64'd0);
    cmp("lit_wrap_nonempty", 64'(ras_empty), 64'd0);
    step(0, 0, 0, 0, 0, 0, 1, 64'd0, 64'd0);
    cmp("lit_wrap_ret", address, 64'd0);

    idle();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
